// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides and a carry flag.
// Define ALU_SEQ_MUL_EN to build opcode 1001 as an iterative shift-add multiplier.
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry
);

   localparam logic [WIDTH-1:0] W_AMT = WIDTH'(WIDTH);

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;
   localparam int             CNT_W  = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
   localparam logic [3:0]     OP_MUL = 4'b1001;
`else
   typedef enum logic [0:0] {S_IDLE = 1'b0, S_DONE = 1'b1} state_t;
`endif

   state_t           state;
   logic             accept;
   logic [WIDTH:0]   eval_p0;

   // Returns {carry, result}; every non-add/sub opcode leaves the top bit clear.
   function automatic logic [WIDTH:0] alu_eval(input logic [WIDTH-1:0] op_a,
                                               input logic [WIDTH-1:0] op_b,
                                               input logic [3:0]       ctl);
      logic [WIDTH:0]          res;
      logic                    big;
      logic signed [WIDTH-1:0] sa;
      big = (op_b >= W_AMT);
      sa  = op_a;
      res = {1'b0, op_a} + {1'b0, op_b};
      case (ctl)
         4'b0001: res = {1'b0, op_a} - {1'b0, op_b};
         4'b0010: res = {1'b0, ~op_a};
         4'b0011: res = big ? '0 : {1'b0, op_a << op_b};
         4'b0100: res = big ? '0 : {1'b0, op_a >> op_b};
         4'b0101: res = {1'b0, op_a & op_b};
         4'b0110: res = {1'b0, op_a | op_b};
         4'b0111: res = {{WIDTH{1'b0}}, op_a < op_b};
         4'b1000: res = (op_a == op_b) ? (WIDTH+1)'(9) : (WIDTH+1)'(7);
         4'b1010: res = big ? {1'b0, {WIDTH{op_a[WIDTH-1]}}} : {1'b0, sa >>> op_b};
         4'b1011: res = {1'b0, op_a ^ op_b};
         default: ;
      endcase
      return res;
   endfunction

   assign eval_p0   = alu_eval(a, b, alu_control);
   assign out_valid = (state == S_DONE);
   assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
   assign accept    = in_valid & in_ready;

`ifdef ALU_SEQ_MUL_EN
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic [CNT_W-1:0] count;

   assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         result <= '0;
         zero   <= 1'b0;
         carry  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
`endif
      end else begin
         case (state)
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
               if (count == LAST) begin
                  result <= acc_nxt;
                  zero   <= (acc_nxt == '0);
                  carry  <= 1'b0;
                  state  <= S_DONE;
               end
            end
`endif
            default: begin
               // IDLE and DONE both accept; DONE only when the consumer takes the old result.
               if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                  if (alu_control == OP_MUL) begin
                     mcand  <= a;
                     mplier <= b;
                     acc    <= '0;
                     count  <= '0;
                     state  <= S_MUL;
                  end else
`endif
                  begin
                     result <= eval_p0[WIDTH-1:0];
                     zero   <= (eval_p0[WIDTH-1:0] == '0);
                     carry  <= eval_p0[WIDTH];
                     state  <= S_DONE;
                  end
               end else if ((state == S_DONE) && out_ready) begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expectations are queued on accept and compared when results are offered.
module tb_alu_seq;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   alu_control;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         zero;
   logic         carry;

   alu_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .alu_control (alu_control),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .carry       (carry)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] res;
      logic         z;
      logic         c;
      int           acc;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   logic busy = 1'b0;
   logic prev_vld = 1'b0;
   logic prev_pop = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Reference behaviour; lat counts edges from the accept edge to out_valid rising.
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t   e;
      longint ux;
      longint uy;
      longint sx;
      longint r;
      longint mask;
      ux    = longint'(x);
      uy    = longint'(y);
      mask  = (longint'(1) << W) - 1;
      e.c   = 1'b0;
      e.lat = 0;
      e.acc = 0;
      case (op)
         4'd1: begin r = ux - uy; e.c = (ux < uy); end
         4'd2: r = ~ux;
         4'd3: r = (uy >= W) ? 0 : (ux << uy);
         4'd4: r = (uy >= W) ? 0 : (ux >> uy);
         4'd5: r = ux & uy;
         4'd6: r = ux | uy;
         4'd7: r = (ux < uy) ? 1 : 0;
         4'd8: r = (ux == uy) ? 9 : 7;
         4'd10: begin
            sx = x[W-1] ? (ux - (longint'(1) << W)) : ux;
            r  = sx >>> ((uy >= W) ? W : uy);
         end
         4'd11: r = ux ^ uy;
`ifdef ALU_SEQ_MUL_EN
         4'd9: begin r = ux * uy; e.lat = W; end
`endif
         default: begin r = ux + uy; e.c = (r > mask); end
      endcase
      r     = r & mask;
      e.res = r[W-1:0];
      e.z   = (e.res == '0);
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         check("rst_out_valid", out_valid, 0);
         check("rst_in_ready", in_ready, 1);
         check("rst_result", result, 0);
         check("rst_zero", zero, 0);
         check("rst_carry", carry, 0);
         sb.delete();
         busy     = 1'b0;
         prev_vld = 1'b0;
         prev_pop = 1'b0;
      end else begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("stale_out_valid", 1, 0);
            end else begin
               if (!prev_vld || prev_pop) check("latency", cyc - sb[0].acc, sb[0].lat);
               check("result", result, sb[0].res);
               check("zero", zero, sb[0].z);
               check("carry", carry, sb[0].c);
               if (out_ready) void'(sb.pop_front());
            end
            busy = 1'b0;
         end
         check("in_ready", in_ready, out_valid ? out_ready : !busy);
         if (in_valid && in_ready) begin
            e     = model(alu_control, a, b);
            e.acc = cyc + 1;
            sb.push_back(e);
`ifdef ALU_SEQ_MUL_EN
            busy = (alu_control == 4'd9);
`endif
         end
         prev_vld = out_valid;
         prev_pop = out_valid && out_ready;
      end
   end

   task automatic wait_accept();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) return;
      end
      check("accept_timeout", 0, 1);
   endtask

   task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      @(posedge clk);
      #2;
      alu_control = op;
      a           = x;
      b           = y;
      in_valid    = 1'b1;
      wait_accept();
   endtask

   // Drop the request and scramble operands so late changes would show up in results.
   task automatic idle();
      @(posedge clk);
      #2;
      in_valid    = 1'b0;
      a           = W'($urandom);
      b           = W'($urandom);
      alu_control = 4'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      check("drain", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      a           = '0;
      b           = '0;
      alu_control = '0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;

      issue(4'd0, 16'hFFFF, 16'h0001);
      issue(4'd1, 16'h0003, 16'h0005);
      issue(4'd3, 16'h0001, 16'd4);
      issue(4'd3, 16'h0001, 16'd16);
      issue(4'd10, 16'h8000, 16'd15);
      issue(4'd10, 16'h8000, 16'd40);
      issue(4'd10, 16'h4000, 16'd20);
      issue(4'd8, 16'h0055, 16'h0055);
      issue(4'd8, 16'h0055, 16'h0056);
      issue(4'd7, 16'd3, 16'd5);
      issue(4'd7, 16'd5, 16'd3);
      issue(4'd2, 16'h00FF, 16'h0000);
      issue(4'd4, 16'h8000, 16'd3);
      issue(4'd4, 16'hFFFF, 16'd17);
      issue(4'd5, 16'hF0F0, 16'h3C3C);
      issue(4'd6, 16'hF000, 16'h000F);
      issue(4'd15, 16'h8000, 16'h8000);
      issue(4'd12, 16'h1234, 16'h1111);
      issue(4'd9, 16'd3, 16'd4);
`ifdef ALU_SEQ_MUL_EN
      issue(4'd9, 16'h0123, 16'h0010);
      issue(4'd9, 16'hFFFF, 16'hFFFF);
`endif
      idle();
      drain();

      @(posedge clk);
      #2 out_ready = 1'b0;
      issue(4'd11, 16'hF0F0, 16'h0FF0);
      idle();
      repeat (5) @(posedge clk);
      #2;
      out_ready   = 1'b1;
      alu_control = 4'd0;
      a           = 16'h0100;
      b           = 16'h0023;
      in_valid    = 1'b1;
      wait_accept();
      issue(4'd0, 16'h7FFF, 16'h0001);
      issue(4'd0, 16'hFFFE, 16'h0003);
      idle();
      drain();

`ifdef ALU_SEQ_MUL_EN
      issue(4'd9, 16'h0123, 16'h0010);
      idle();
      repeat (7) @(posedge clk);
`else
      @(posedge clk);
      #2 out_ready = 1'b0;
      issue(4'd11, 16'hF0F0, 16'h0FF0);
      idle();
      repeat (3) @(posedge clk);
`endif
      #2 rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_result", result, 0);
      @(posedge clk);
      #2;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1 check("abort_in_ready", in_ready, 1);
      repeat (25) @(posedge clk);

      for (int i = 0; i < 30; i++) issue(4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
      idle();
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
